// File: rtl/bram_result_reader_pkg.sv
// Shared definitions for the BRAM result reader.
//   state_t        : reader FSM encoding (IDLE / RUN / DONE)
//   WORDS_PER_ROW  : result words packed into one BRAM1 row
//   WORD_IDX_W     : width of the word index within a row
package bram_result_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WORDS_PER_ROW = 4;
  localparam int WORD_IDX_W    = 2;

endpackage

// File: rtl/bram_result_reader_unpacker.sv
// bram_row_unpacker: holds one BRAM1 row and streams it out as
// WORDS_PER_ROW words, most significant word first, over valid/ready.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   load              capture load_data into the row buffer this cycle
//   load_data         BRAM1 row
//   load_last         the row being loaded is the final row of the run
//   m_ready_i         downstream accept
//   m_valid_o         buffered word available
//   m_data_o          current word
//   m_last_o          current word is the final word of the run
//   row_done_o        last word of the buffered row is accepted this cycle
module bram_row_unpacker
  import bram_result_reader_pkg::*;
#(
  parameter int DWIDTH     = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DWIDTH-1:0]     load_data,
  input  logic                  load_last,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [WORD_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  row_done_o
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_ROW - 1);

  logic [DWIDTH-1:0]     row_buf;
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  buf_valid;
  logic                  row_is_last;
  logic [WORD_WIDTH-1:0] words [WORDS_PER_ROW];
  logic                  accept;

  // Word 0 sits in the top bits of the row.
  for (genvar gi = 0; gi < WORDS_PER_ROW; gi++) begin : g_word
    assign words[gi] = row_buf[DWIDTH-1-gi*WORD_WIDTH -: WORD_WIDTH];
  end

  assign accept     = buf_valid && m_ready_i;
  assign m_valid_o  = buf_valid;
  assign m_data_o   = words[word_idx];
  assign m_last_o   = buf_valid && row_is_last && (word_idx == LAST_IDX);
  assign row_done_o = accept && (word_idx == LAST_IDX);

  // A load never coincides with the final accept of a row: the read that
  // feeds the next row is only issued on that accept, so the data arrives
  // one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_buf     <= '0;
      word_idx    <= '0;
      buf_valid   <= 1'b0;
      row_is_last <= 1'b0;
    end else if (load) begin
      row_buf     <= load_data;
      word_idx    <= '0;
      buf_valid   <= 1'b1;
      row_is_last <= load_last;
    end else if (accept) begin
      if (word_idx == LAST_IDX) begin
        word_idx  <= '0;
        buf_valid <= 1'b0;
      end else begin
        word_idx <= word_idx + WORD_IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/bram_result_reader.sv
// bram_result_reader: reads run_count rows from BRAM1 starting at address 0
// and streams each row as four 32-bit words over a valid/ready interface.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start_run_i             start pulse (honoured only in IDLE)
//   run_count_i             number of rows, captured with start_run_i
//   addr_b1_o/ce_b1_o/we_b1_o  BRAM1 read port control (we always 0)
//   q_b1_i                  BRAM1 data, valid the cycle after ce_b1_o
//   m_valid_o/m_ready_i/m_data_o/m_last_o  result word stream
//   idle_o/read_o/done_o    FSM state flags
module bram_result_reader
  import bram_result_reader_pkg::*;
#(
  parameter int CNT_BIT    = 31,
  parameter int DWIDTH     = 128,
  parameter int AWIDTH     = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_run_i,
  input  logic [CNT_BIT-1:0]    run_count_i,
  output logic [AWIDTH-1:0]     addr_b1_o,
  output logic                  ce_b1_o,
  output logic                  we_b1_o,
  input  logic [DWIDTH-1:0]     q_b1_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WORD_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  idle_o,
  output logic                  read_o,
  output logic                  done_o
);

  state_t               state, state_next;
  logic [CNT_BIT-1:0]   row_total;
  logic [CNT_BIT-1:0]   row_cnt;
  logic                 pending;
  logic                 pending_last;
  logic                 rows_left;
  logic                 issue_last;
  logic                 row_done;
  logic                 buf_valid;
  logic                 ce;

  assign rows_left  = row_cnt < row_total;
  assign issue_last = row_cnt == (row_total - CNT_BIT'(1));

  always_comb begin
    state_next = state;
    ce         = 1'b0;
    idle_o     = 1'b0;
    read_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        idle_o = 1'b1;
        if (start_run_i) begin
          state_next = (run_count_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        read_o = 1'b1;
        // Issue a read when nothing is buffered or in flight, or back-to-back
        // with the accept of the final word of the buffered row.
        ce = rows_left && ((!buf_valid && !pending) || row_done);
        if (m_valid_o && m_ready_i && m_last_o) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      row_total    <= '0;
      row_cnt      <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      state        <= state_next;
      pending      <= ce;
      pending_last <= ce && issue_last;
      if (state == IDLE && start_run_i) begin
        row_total <= run_count_i;
        row_cnt   <= '0;
      end else if (ce) begin
        row_cnt <= row_cnt + CNT_BIT'(1);
      end
    end
  end

  assign addr_b1_o = row_cnt[AWIDTH-1:0];
  assign ce_b1_o   = ce;
  assign we_b1_o   = 1'b0;

  bram_row_unpacker #(
    .DWIDTH     (DWIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .load       (pending),
    .load_data  (q_b1_i),
    .load_last  (pending_last),
    .m_ready_i  (m_ready_i),
    .m_valid_o  (buf_valid),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .row_done_o (row_done)
  );

  assign m_valid_o = buf_valid;

endmodule

// File: doc/bram_result_reader.md
BRAM_RESULT_READER -- requirements
Module: bram_result_reader

Interface
REQ-001 Parameter CNT_BIT, 31, width of the row count and row counter.
REQ-002 Parameter DWIDTH, 128, BRAM1 row width (four result words).
REQ-003 Parameter AWIDTH, 8, BRAM1 address width.
REQ-004 Parameter WORD_WIDTH, 32, width of each streamed result word.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start_run_i  in  1  start pulse, sampled only in IDLE.
REQ-008 run_count_i  in  CNT_BIT  number of BRAM1 rows to read, captured with start_run_i.
REQ-009 addr_b1_o  out  AWIDTH  BRAM1 read address.
REQ-010 ce_b1_o  out  1  BRAM1 chip enable, one cycle per row read.
REQ-011 we_b1_o  out  1  BRAM1 write enable, constant 0.
REQ-012 q_b1_i  in  DWIDTH  BRAM1 read data, valid the cycle after ce_b1_o.
REQ-013 m_valid_o  out  1  result word valid.
REQ-014 m_ready_i  in  1  downstream accept.
REQ-015 m_data_o  out  WORD_WIDTH  result word.
REQ-016 m_last_o  out  1  marks the final word of the run.
REQ-017 idle_o / read_o / done_o  out  1 each  state flags: IDLE / RUN / DONE.

Function
REQ-018 The FSM SHALL have three states, IDLE, RUN and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-019 In IDLE, start_run_i=1 SHALL capture run_count_i and go to RUN; if run_count_i=0, it SHALL go directly to DONE with no ce_b1_o and no m_valid_o.
REQ-020 start_run_i in RUN or DONE SHALL be ignored.
REQ-021 The block SHALL assert ce_b1_o in RUN, with rows remaining, in either of two cases: the row buffer is empty with no read pending; or the last word of the buffered row is accepted in that cycle.
REQ-022 addr_b1_o SHALL equal the row counter truncated to AWIDTH bits (wraps modulo 2^AWIDTH); the counter SHALL increment once per issued read.
REQ-023 q_b1_i SHALL be registered into a row buffer in the cycle after ce_b1_o, and m_valid_o SHALL assert in the following cycle.
REQ-024 Word order SHALL be word0=q[127:96], word1=q[95:64], word2=q[63:32], word3=q[31:0].
REQ-025 A word SHALL transfer only when m_valid_o=1 and m_ready_i=1; while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o SHALL hold stable and no new read SHALL issue.
REQ-026 m_valid_o SHALL never drop without a transfer, except on reset.
REQ-027 With m_ready_i held at 1, throughput SHALL be four words per five cycles, with one bubble between rows.
REQ-028 m_last_o SHALL be 1 only with word3 of row run_count-1.
REQ-029 Acceptance of the last word SHALL move the FSM to DONE in the next cycle.
REQ-030 The first m_valid_o SHALL occur three cycles after the start_run_i cycle.

Reset
REQ-031 Reset SHALL act immediately and clear the FSM (to IDLE), counters, row buffer and pending flag.
REQ-032 Reset values SHALL be: addr_b1_o=0, ce_b1_o=0, we_b1_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, idle_o=1, read_o=0, done_o=0.
REQ-033 Reset asserted mid-run SHALL abandon the run; after reset is released, a new start SHALL begin at address 0.

Structure
REQ-034 The shared package SHALL hold the state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10 and the constant WORDS_PER_ROW=4.
REQ-035 The row buffer, word index and valid/ready logic SHALL form one sub-module, bram_row_unpacker; the FSM and read issue SHALL remain in bram_result_reader.

Verification
REQ-036 Basic run: rows 0x00000001_00000002_00000003_00000004 and 0x00000005_00000006_00000007_00000008, run_count=2, ready=1, start at cycle 0 -> words 1..4 at cycles 3-6, 5..8 at cycles 8-11, m_last_o at cycle 11, done_o at cycle 12, idle_o at cycle 13.
REQ-037 Zero count: run_count=0 -> done_o the next cycle; ce_b1_o and m_valid_o never assert.
REQ-038 Backpressure: m_ready_i=0 for 3 cycles while word1 is valid -> m_data_o held at word1, no ce_b1_o, addr_b1_o unchanged; the stream resumes in order.
REQ-039 Wrap: AWIDTH=8, run_count=258 -> read addresses 0..255, 0, 1; m_last_o only on the final word; 1032 words total.
REQ-040 Reset and restart: reset during row 1, word 2 -> all outputs at reset values while reset is high; a later start with run_count=1 reads address 0.
REQ-041 Spurious start: start_run_i pulses during RUN -> no effect on count, addresses or stream.
